riscv_muldiv_unit: RTL

//  Iterative RV32M/RV64M multiply/divide unit; companion to the combinational ALU operation decoder.

---
 rtl/riscv_muldiv_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit for the EX stage.
//   Radix-2: one product or quotient bit per cycle. Divide-by-zero and
//   signed-overflow divides bypass the iteration and resolve in one cycle.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         synchronous active-high reset; aborts any operation in flight
//   start_valid   operation request
//   start_ready   unit can accept (high only in IDLE)
//   Funct3        M-extension funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   operand_a     rs1 (multiplicand / dividend)
//   operand_b     rs2 (multiplier / divisor)
//   result_valid  result available, held until result_ready
//   result_ready  consumer takes the result
//   result        rd value; keeps its last value while result_valid is low
//   busy          state is not IDLE

module riscv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST  = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       count_q;
  logic [2:0]          op_q;
  logic                neg_q;          // final result must be negated
  logic                fast_q;         // fast-path result already known
  logic [XLEN-1:0]     fast_result_q;
  logic [XLEN-1:0]     opnd_q;         // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0]   acc_q;          // {hi, lo}: product accumulator or {remainder, quotient}
  logic [XLEN-1:0]     result_q;
  logic                result_valid_q;

  // ---------------- accept-time decode ----------------
  logic            a_signed_in, b_signed_in;
  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero_in, div_ovf_in, fast_in, neg_in;
  logic [XLEN-1:0] fast_result_in;

  always_comb begin
    a_signed_in = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                  (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_signed_in = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    a_neg_in    = a_signed_in && operand_a[XLEN-1];
    b_neg_in    = b_signed_in && operand_b[XLEN-1];
    // -SMIN wraps to SMIN, which is the correct unsigned magnitude 2^(XLEN-1)
    mag_a_in    = a_neg_in ? (~operand_a + 1'b1) : operand_a;
    mag_b_in    = b_neg_in ? (~operand_b + 1'b1) : operand_b;

    div_zero_in = Funct3[2] && (operand_b == '0);
    div_ovf_in  = Funct3[2] && !Funct3[0] && (operand_a == SMIN) && (operand_b == '1);
    fast_in     = div_zero_in || div_ovf_in;

    fast_result_in = '0;
    if (div_zero_in)
      fast_result_in = Funct3[1] ? operand_a : '1;
    else if (div_ovf_in)
      fast_result_in = Funct3[1] ? '0 : operand_a;

    // Remainder follows the dividend sign; quotient and products follow sa^sb.
    // MUL is decoded as unsigned: its low half is sign-independent.
    if (Funct3[2] && Funct3[1])
      neg_in = a_neg_in;
    else
      neg_in = a_neg_in ^ b_neg_in;
  end

  // ---------------- iteration datapath ----------------
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_d;

  always_comb begin
    acc_hi = acc_q[2*XLEN-1:XLEN];
    acc_lo = acc_q[XLEN-1:0];

    // Shift-add: conditionally add multiplicand to the high half, then shift
    // the whole accumulator right, carry included.
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_lo[XLEN-1:1]};

    // Restoring divide: bring in the next dividend bit, subtract if it fits.
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                 acc_lo[XLEN-2:0], div_ge};

    acc_d = op_q[2] ? div_next : mul_next;
  end

  // ---------------- sign fix-up and result select ----------------
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   div_pick;
  logic [XLEN-1:0]   final_result;

  always_comb begin
    prod_signed = neg_q ? (~acc_d + 1'b1) : acc_d;
    div_pick    = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
    if (op_q[2])
      final_result = neg_q ? (~div_pick + 1'b1) : div_pick;
    else if (op_q[1:0] == 2'b00)
      final_result = prod_signed[XLEN-1:0];
    else
      final_result = prod_signed[2*XLEN-1:XLEN];
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      op_q           <= '0;
      neg_q          <= 1'b0;
      fast_q         <= 1'b0;
      fast_result_q  <= '0;
      opnd_q         <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            op_q          <= Funct3;
            neg_q         <= neg_in;
            fast_q        <= fast_in;
            fast_result_q <= fast_result_in;
            count_q       <= '0;
            if (Funct3[2]) begin
              opnd_q <= mag_b_in;
              acc_q  <= {{XLEN{1'b0}}, mag_a_in};
            end else begin
              opnd_q <= mag_a_in;
              acc_q  <= {{XLEN{1'b0}}, mag_b_in};
            end
            state_q <= CALC;
          end
        end
        CALC: begin
          // Fast-path operations resolve in their first cycle here.
          if (fast_q) begin
            result_q       <= fast_result_q;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end else begin
            acc_q   <= acc_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST) begin
              result_q       <= final_result;
              result_valid_q <= 1'b1;
              state_q        <= DONE;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          result_valid_q <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign result_valid = result_valid_q;
  assign result       = result_q;

endmodule
